// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite entry type, dirty-state encoding and player index for sprite_state_bank
package sprite_pkg;
  localparam int X_W_DEF = 11;
  localparam int Y_W_DEF = 10;
  localparam int DIR_W_DEF = 4;
  localparam int PLAYER_ID = 0;
  typedef struct packed {
    logic [X_W_DEF-1:0] x;
    logic [Y_W_DEF-1:0] y;
    logic [DIR_W_DEF-1:0] dir;
  } sprite_t;
  typedef enum logic {IDLE, DIRTY} state_t;
endpackage

// File: rtl/sprite_collide_cmp.sv
// sprite_collide_cmp: flags every sprite whose x/y equals the player's (used with SPRITE_COLLIDE_EN)
module sprite_collide_cmp
  import sprite_pkg::*;
#(
  parameter int N_SPRITES = 5,
  parameter int X_W = 11,
  parameter int Y_W = 10
) (
  input  logic [N_SPRITES*X_W-1:0] xs,
  input  logic [N_SPRITES*Y_W-1:0] ys,
  output logic [N_SPRITES-1:0]     hit
);
  for (genvar i = 0; i < N_SPRITES; i++) begin : g_cmp
    if (i == PLAYER_ID) begin : g_self
      assign hit[i] = 1'b0;
    end else begin : g_other
      assign hit[i] = xs[i*X_W +: X_W] == xs[PLAYER_ID*X_W +: X_W] &&
                      ys[i*Y_W +: Y_W] == ys[PLAYER_ID*Y_W +: Y_W];
    end
  end
endmodule

// File: rtl/sprite_state_bank.sv
// sprite_state_bank: frame-synchronised double-buffered sprite state; SPRITE_COLLIDE_EN adds player collision outputs
module sprite_state_bank
  import sprite_pkg::*;
#(
  parameter int N_SPRITES = 5,
  parameter int X_W = 11,
  parameter int Y_W = 10,
  parameter int DIR_W = 4,
  parameter int ID_W = $clog2(N_SPRITES),
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ID_W-1:0]   wr_id,
  input  logic [X_W-1:0]    wr_x,
  input  logic [Y_W-1:0]    wr_y,
  input  logic [DIR_W-1:0]  wr_dir,
  input  logic              frame_sync,
  input  logic              freeze,
  input  logic [ID_W-1:0]   rd_id,
  output logic [X_W-1:0]    rd_x,
  output logic [Y_W-1:0]    rd_y,
  output logic [DIR_W-1:0]  rd_dir,
  output logic              committed,
  output logic [FCNT_W-1:0] frame_cnt,
`ifdef SPRITE_COLLIDE_EN
  output logic                 collide,
  output logic [N_SPRITES-1:0] collide_mask,
`endif
  output logic              wr_err
);
  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [DIR_W-1:0] dir;
  } ent_t;
  localparam logic [ID_W:0] N_L = (ID_W+1)'(N_SPRITES);
  ent_t shadow [N_SPRITES];
  ent_t active [N_SPRITES];
  ent_t rd_q;
  state_t state;
  logic wr_fire, wr_ok, rd_ok, commit;
  assign wr_ready = rst & ~frame_sync;
  assign wr_fire = wr_valid & wr_ready;
  assign wr_ok = {1'b0, wr_id} < N_L;
  assign rd_ok = {1'b0, rd_id} < N_L;
  assign commit = frame_sync & ~freeze & (state == DIRTY);
  assign rd_x = rd_q.x;
  assign rd_y = rd_q.y;
  assign rd_dir = rd_q.dir;
  // shadow takes game-logic writes; active copies the whole shadow on commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_fire && wr_ok) shadow[wr_id] <= '{x: wr_x, y: wr_y, dir: wr_dir};
      if (commit) for (int i = 0; i < N_SPRITES; i++) active[i] <= shadow[i];
    end
  end
  // dirty tracking, commit pulse, frame counter and sticky bad-id flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      committed <= 1'b0;
      frame_cnt <= '0;
      wr_err <= 1'b0;
    end else begin
      state <= commit ? IDLE : (wr_fire && wr_ok) ? DIRTY : state;
      committed <= commit;
      frame_cnt <= frame_cnt + FCNT_W'(commit);
      wr_err <= wr_err | (wr_fire & ~wr_ok);
    end
  end
  // registered read of the active bank; out-of-range ids read as zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_q <= '0;
    else rd_q <= rd_ok ? active[rd_id] : '0;
  end
`ifdef SPRITE_COLLIDE_EN
  logic [N_SPRITES*X_W-1:0] xs;
  logic [N_SPRITES*Y_W-1:0] ys;
  logic [N_SPRITES-1:0] hit;
  // flatten shadow positions for the comparator array
  always_comb begin
    xs = '0;
    ys = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      xs[i*X_W +: X_W] = shadow[i].x;
      ys[i*Y_W +: Y_W] = shadow[i].y;
    end
  end
  sprite_collide_cmp #(.N_SPRITES(N_SPRITES), .X_W(X_W), .Y_W(Y_W)) u_cmp (
    .xs (xs),
    .ys (ys),
    .hit(hit)
  );
  // collision result captured from the bank being committed, held until the next commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      collide <= 1'b0;
      collide_mask <= '0;
    end else if (commit) begin
      collide <= |hit;
      collide_mask <= hit;
    end
  end
`endif
endmodule

// File: doc/sprite_state_bank.md
Name: sprite_state_bank

Overview:
- Parametrised, frame-synchronised, double-buffered store of sprite state: block x, block y and direction for N sprites, e.g. pacman plus ghosts.
- Game logic writes a shadow bank at any time through a valid/ready port.
- A frame-boundary pulse from the video timing side commits the shadow bank atomically into the active bank.
- The renderer reads only the active bank, so a sprite set never tears mid-frame.
- Generalises the fixed, ungated 5-sprite position wiring to N sprites with configurable widths, commit gating and a frame counter.

Parameters:
- N_SPRITES, 5, number of sprite entries (≥2); entry 0 is the player.
- X_W, 11, x position width.
- Y_W, 10, y position width.
- DIR_W, 4, direction field width.
- ID_W, $clog2(N_SPRITES), sprite index width.
- FCNT_W, 16, frame-commit counter width.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_id  in  ID_W  target sprite.
- wr_x  in  X_W  new x.
- wr_y  in  Y_W  new y.
- wr_dir  in  DIR_W  new direction.
- frame_sync  in  1  one-cycle pulse at start of vblank.
- freeze  in  1  suppresses commits while high, e.g. on player death.
- rd_id  in  ID_W  active-bank read index.
- rd_x  out  X_W  active x of rd_id.
- rd_y  out  Y_W  active y of rd_id.
- rd_dir  out  DIR_W  active dir of rd_id.
- committed  out  1  one-cycle pulse when a commit happened.
- frame_cnt  out  FCNT_W  number of commits since reset.
- wr_err  out  1  sticky flag: a write with wr_id ≥ N_SPRITES was accepted.

Behaviour:
- Reset (rst low, async): all shadow and active entries = 0; rd_* = 0; committed = 0; frame_cnt = 0; wr_err = 0; dirty = 0. wr_ready = 0 while in reset.
- wr_ready = !frame_sync. Writes stall on the commit cycle only.
- Accepted write:
  - wr_id < N_SPRITES: shadow[wr_id] <= {wr_x, wr_y, wr_dir} at the next edge, and the dirty flag is set.
  - Otherwise: data is dropped, wr_err <= 1 (cleared only by reset), and dirty is unchanged.
- Multiple writes to the same id within a frame: last one wins.
- Commit condition, evaluated on a cycle where frame_sync = 1: !freeze && dirty.
  - On commit: active <= shadow (all entries in the same edge), dirty <= 0, committed <= 1 for exactly one cycle, frame_cnt <= frame_cnt + 1 (wraps modulo 2^FCNT_W).
  - frame_sync with freeze = 1 or dirty = 0: no change to the active bank, no committed pulse, no count. Dirty is retained while frozen.
- Read port:
  - Registered, 1-cycle latency: rd_* at edge n+1 reflect active[rd_id] as sampled at edge n.
  - Out-of-range rd_id returns 0.
  - A read on a commit edge returns the pre-commit value; post-commit data appears at the next edge.
- frame_sync held high for k cycles is treated as k commit opportunities. Only the first can commit because dirty is cleared; wr_ready stays low throughout.
- Async reset mid-frame discards the shadow bank and any pending commit.
- State machine: IDLE/DIRTY, a 1-bit dirty flag. IDLE→DIRTY on a valid write; DIRTY→IDLE on commit.
- Arithmetic: unsigned positions, no saturation, no bounds checking beyond id.

Optional Feature:
- Macro: SPRITE_COLLIDE_EN.
- When defined, adds outputs collide (1) and collide_mask (N_SPRITES), both reset to 0.
- On each commit edge (same edge as active is written), the block registers:
  - collide_mask[i] = (shadow[i].x == shadow[0].x && shadow[i].y == shadow[0].y) for i ≥ 1;
  - collide_mask[0] = 0;
  - collide = |collide_mask.
- Both outputs hold until the next commit.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package sprite_pkg: typedef sprite_t {x, y, dir} using X_W/Y_W/DIR_W defaults; constant PLAYER_ID = 0.
- Parameter overrides remain at module level.
- One natural sub-module: sprite_collide_cmp, the per-entry equality compare array, instantiated only under SPRITE_COLLIDE_EN.

Test Plan:
- Reset → all rd_* = 0, frame_cnt = 0, wr_err = 0, wr_ready = 0 during reset.
- Write id2 = (100, 50, 4'h2), then frame_sync → committed pulses once; frame_cnt = 1; after 1 cycle rd_id = 2 gives (100, 50, 2). Before the sync, the same read gives (0, 0, 0).
- Writes id1 = (10, 10), then id1 = (20, 20), then frame_sync → rd gives (20, 20). A frame_sync with no new write → no committed pulse, frame_cnt stays 1.
- freeze = 1, write id3 = (7, 7), frame_sync → no commit. Then freeze = 0, frame_sync → commit, rd_id = 3 gives (7, 7).
- wr_valid with frame_sync same cycle → wr_ready = 0, write not taken. wr_id = 6 with N_SPRITES = 5 → wr_err = 1 and stays 1; no dirty set.
- SPRITE_COLLIDE_EN: id0 = (30, 40), id3 = (30, 40), id1 = (31, 40), commit → collide = 1, collide_mask = 5'b01000.
